// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the five-stage MIPS pipeline: load-use stalls
// with multi-cycle load latency, mult/div HI/LO interlock, flush priority and perf counters.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_branch,
  input  logic              ex_zf,
  input  logic              ex_jump,
  input  logic              ex_memrd,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_md_start,
  input  logic              id_hilo_rd,
  input  logic              id_md_op,
  input  logic              cnt_clr,
  output logic              clear1,
  output logic              clear0,
  output logic              idex_bubble,
  output logic              if_id_wr,
  output logic              pc_wr,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int LD_W = $clog2(LOAD_LAT + 1);
  localparam int MD_W = $clog2(MD_LAT + 1);

  localparam logic [LD_W-1:0]  LD_INIT = LD_W'(LOAD_LAT - 1);
  localparam logic [LD_W-1:0]  LD_ONE  = LD_W'(1);
  localparam logic [MD_W-1:0]  MD_INIT = MD_W'(MD_LAT);
  localparam logic [MD_W-1:0]  MD_ONE  = MD_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, LD_WAIT} ld_state_t;

  ld_state_t        state_q, state_d;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic flush, ld_hit, md_hit, ld_stall, stall, busy;

  assign busy   = (md_cnt_q != '0);
  assign flush  = ~rst & ((ex_branch & ex_zf) | ex_jump);
  assign ld_hit = ex_memrd & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign md_hit = busy & (id_hilo_rd | id_md_op);

  // Load FSM: first stall cycle is taken from IDLE, the remaining LOAD_LAT-1 in LD_WAIT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    ld_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_hit && !flush) begin
          ld_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d  = LD_WAIT;
            ld_cnt_d = LD_INIT;
          end
        end
      end
      LD_WAIT: begin
        if (flush) begin
          state_d  = IDLE;
          ld_cnt_d = '0;
        end else begin
          ld_stall = 1'b1;
          ld_cnt_d = ld_cnt_q - LD_ONE;
          if (ld_cnt_q == LD_ONE) state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        ld_cnt_d = '0;
      end
    endcase
  end

  // A flushed mult/div never starts; one already running keeps counting down.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (ex_md_start && !flush) md_cnt_d = MD_INIT;
    else if (busy)             md_cnt_d = md_cnt_q - MD_ONE;
  end

  assign stall = ~rst & ~flush & (ld_stall | md_hit);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      md_cnt_q <= md_cnt_d;
      if (cnt_clr) begin
        stall_cnt_q <= '0;
        flush_cnt_q <= '0;
      end else begin
        if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
        if (flush && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign clear1      = flush;
  assign clear0      = flush;
  assign idex_bubble = stall;
  assign if_id_wr    = ~stall;
  assign pc_wr       = ~stall;
  assign md_busy     = busy & ~rst;
  assign stall_cnt   = rst ? '0 : stall_cnt_q;
  assign flush_cnt   = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share stimulus and are compared against a cycle-count reference model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_branch, ex_zf, ex_jump, ex_memrd;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       ex_md_start, id_hilo_rd, id_md_op, cnt_clr;

  logic        a_clear1, a_clear0, a_idex_bubble, a_if_id_wr, a_pc_wr, a_md_busy;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_clear1, b_clear0, b_idex_bubble, b_if_id_wr, b_pc_wr, b_md_busy;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ex_branch(ex_branch), .ex_zf(ex_zf), .ex_jump(ex_jump),
    .ex_memrd(ex_memrd), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_md_start(ex_md_start), .id_hilo_rd(id_hilo_rd), .id_md_op(id_md_op), .cnt_clr(cnt_clr),
    .clear1(a_clear1), .clear0(a_clear0), .idex_bubble(a_idex_bubble), .if_id_wr(a_if_id_wr),
    .pc_wr(a_pc_wr), .md_busy(a_md_busy), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .ex_branch(ex_branch), .ex_zf(ex_zf), .ex_jump(ex_jump),
    .ex_memrd(ex_memrd), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_md_start(ex_md_start), .id_hilo_rd(id_hilo_rd), .id_md_op(id_md_op), .cnt_clr(cnt_clr),
    .clear1(b_clear1), .clear0(b_clear0), .idex_bubble(b_idex_bubble), .if_id_wr(b_if_id_wr),
    .pc_wr(b_pc_wr), .md_busy(b_md_busy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  typedef struct {
    bit c1, c0, bub, ifw, pcw, busy;
    int sc, fc;
  } obs_t;

  typedef struct {
    bit       br, zf, jmp, mrd;
    bit [4:0] ert, rs, rt;
    bit       exp_flush, exp_stall;
  } vec_t;

  // Reference model: remaining stall / busy cycles and counter values per instance.
  int p_ll[2]  = '{1, 3};
  int p_md[2]  = '{4, 4};
  int p_max[2] = '{65535, 15};
  int m_ld[2]  = '{0, 0};
  int m_md[2]  = '{0, 0};
  int m_sc[2]  = '{0, 0};
  int m_fc[2]  = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic obs_t get_obs(int i);
    obs_t o;
    if (i == 0) begin
      o.c1 = a_clear1; o.c0 = a_clear0; o.bub = a_idex_bubble; o.ifw = a_if_id_wr;
      o.pcw = a_pc_wr; o.busy = a_md_busy; o.sc = int'(a_stall_cnt); o.fc = int'(a_flush_cnt);
    end else begin
      o.c1 = b_clear1; o.c0 = b_clear0; o.bub = b_idex_bubble; o.ifw = b_if_id_wr;
      o.pcw = b_pc_wr; o.busy = b_md_busy; o.sc = int'(b_stall_cnt); o.fc = int'(b_flush_cnt);
    end
    return o;
  endfunction

  function automatic bit m_flush();
    return (ex_branch && ex_zf) || ex_jump;
  endfunction

  function automatic bit m_stall(int i);
    bit hit;
    hit = ex_memrd && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    return !m_flush() && ((m_ld[i] > 0) || hit || ((m_md[i] > 0) && (id_hilo_rd || id_md_op)));
  endfunction

  function automatic obs_t model_eval(int i);
    obs_t e;
    bit st;
    if (rst) begin
      e.c1 = 0; e.c0 = 0; e.bub = 0; e.ifw = 1; e.pcw = 1; e.busy = 0; e.sc = 0; e.fc = 0;
      return e;
    end
    st = m_stall(i);
    e.c1 = m_flush(); e.c0 = m_flush(); e.bub = st; e.ifw = !st; e.pcw = !st;
    e.busy = (m_md[i] > 0); e.sc = m_sc[i]; e.fc = m_fc[i];
    return e;
  endfunction

  task automatic model_update(int i);
    bit fl, st, hit;
    if (rst) begin
      m_ld[i] = 0; m_md[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      return;
    end
    fl  = m_flush();
    st  = m_stall(i);
    hit = ex_memrd && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    if (cnt_clr) begin
      m_sc[i] = 0; m_fc[i] = 0;
    end else begin
      if (st && m_sc[i] < p_max[i]) m_sc[i]++;
      if (fl && m_fc[i] < p_max[i]) m_fc[i]++;
    end
    if (fl)               m_ld[i] = 0;
    else if (m_ld[i] > 0) m_ld[i]--;
    else if (hit)         m_ld[i] = p_ll[i] - 1;
    if (ex_md_start && !fl) m_md[i] = p_md[i];
    else if (m_md[i] > 0)   m_md[i]--;
  endtask

  // Wait to mid-cycle and compare every output of both instances to the model.
  task automatic settle();
    obs_t e, o;
    string p;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "A" : "B";
      e = model_eval(i);
      o = get_obs(i);
      check({p, ".clear1"},      int'(o.c1),   int'(e.c1));
      check({p, ".clear0"},      int'(o.c0),   int'(e.c0));
      check({p, ".idex_bubble"}, int'(o.bub),  int'(e.bub));
      check({p, ".if_id_wr"},    int'(o.ifw),  int'(e.ifw));
      check({p, ".pc_wr"},       int'(o.pcw),  int'(e.pcw));
      check({p, ".md_busy"},     int'(o.busy), int'(e.busy));
      check({p, ".stall_cnt"},   o.sc, e.sc);
      check({p, ".flush_cnt"},   o.fc, e.fc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    ex_branch = 0; ex_zf = 0; ex_jump = 0; ex_memrd = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0;
    ex_md_start = 0; id_hilo_rd = 0; id_md_op = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  vec_t vecs[10];

  initial begin
    idle_inputs();
    rst = 1;

    // Reset state, observed while rst is held.
    settle();
    check("rst.A.pc_wr", int'(a_pc_wr), 1);
    check("rst.B.if_id_wr", int'(b_if_id_wr), 1);
    check("rst.A.clear1", int'(a_clear1), 0);
    check("rst.B.idex_bubble", int'(b_idex_bubble), 0);
    tick();
    rst = 0;
    settle();
    check("rst.A.md_busy", int'(a_md_busy), 0);
    check("rst.B.stall_cnt", int'(b_stall_cnt), 0);
    tick();

    // Single-cycle combinational vectors, each from a freshly reset unit.
    //           br zf jmp mrd ert    rs     rt     flush stall
    vecs[0] = '{0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0};
    vecs[1] = '{1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0};
    vecs[2] = '{1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  1, 0};
    vecs[3] = '{0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  1, 0};
    vecs[4] = '{0, 0, 0, 1, 5'd8,  5'd8,  5'd3,  0, 1};
    vecs[5] = '{0, 0, 0, 1, 5'd8,  5'd3,  5'd8,  0, 1};
    vecs[6] = '{0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  0, 0};
    vecs[7] = '{0, 0, 0, 0, 5'd8,  5'd8,  5'd8,  0, 0};
    vecs[8] = '{0, 0, 0, 1, 5'd31, 5'd15, 5'd14, 0, 0};
    vecs[9] = '{0, 0, 1, 1, 5'd8,  5'd8,  5'd0,  1, 0};
    for (int v = 0; v < 10; v++) begin
      do_reset();
      ex_branch = vecs[v].br; ex_zf = vecs[v].zf; ex_jump = vecs[v].jmp; ex_memrd = vecs[v].mrd;
      ex_rt = vecs[v].ert; id_rs = vecs[v].rs; id_rt = vecs[v].rt;
      settle();
      check($sformatf("vec%0d.A.clear1", v), int'(a_clear1), int'(vecs[v].exp_flush));
      check($sformatf("vec%0d.A.bubble", v), int'(a_idex_bubble), int'(vecs[v].exp_stall));
      check($sformatf("vec%0d.A.pc_wr", v), int'(a_pc_wr), int'(!vecs[v].exp_stall));
      check($sformatf("vec%0d.B.bubble", v), int'(b_idex_bubble), int'(vecs[v].exp_stall));
      tick();
    end

    // Load-use: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 stalls three.
    do_reset();
    ex_memrd = 1; ex_rt = 5'd8; id_rs = 5'd8;
    settle();
    check("ld.c1.A.bubble", int'(a_idex_bubble), 1);
    check("ld.c1.B.bubble", int'(b_idex_bubble), 1);
    tick();
    idle_inputs();
    settle();
    check("ld.c2.A.pc_wr", int'(a_pc_wr), 1);
    check("ld.c2.B.bubble", int'(b_idex_bubble), 1);
    tick();
    settle();
    check("ld.c3.B.bubble", int'(b_idex_bubble), 1);
    tick();
    settle();
    check("ld.c4.B.pc_wr", int'(b_pc_wr), 1);
    check("ld.A.stall_cnt", int'(a_stall_cnt), 1);
    check("ld.B.stall_cnt", int'(b_stall_cnt), 3);
    tick();
    ex_memrd = 1; ex_rt = 5'd0; id_rs = 5'd0;
    settle();
    check("ld.r0.B.bubble", int'(b_idex_bubble), 0);
    tick();
    idle_inputs();
    settle();
    check("ld.r0.next.B.bubble", int'(b_idex_bubble), 0);
    tick();

    // Jump on the second stall cycle of a 3-cycle load stall.
    do_reset();
    ex_memrd = 1; ex_rt = 5'd8; id_rs = 5'd8;
    tick();
    idle_inputs();
    ex_jump = 1;
    settle();
    check("jmp.B.clear1", int'(b_clear1), 1);
    check("jmp.B.clear0", int'(b_clear0), 1);
    check("jmp.B.pc_wr", int'(b_pc_wr), 1);
    check("jmp.B.bubble", int'(b_idex_bubble), 0);
    tick();
    ex_jump = 0;
    settle();
    check("jmp.after.B.bubble", int'(b_idex_bubble), 0);
    check("jmp.B.flush_cnt", int'(b_flush_cnt), 1);
    check("jmp.B.stall_cnt", int'(b_stall_cnt), 1);
    tick();

    // Mult/div busy window with and without a HI/LO reader in ID.
    do_reset();
    ex_md_start = 1;
    settle();
    check("md.start.A.busy", int'(a_md_busy), 0);
    tick();
    ex_md_start = 0; id_hilo_rd = 1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("md.hilo%0d.A.busy", k), int'(a_md_busy), (k < 4) ? 1 : 0);
      check($sformatf("md.hilo%0d.A.bubble", k), int'(a_idex_bubble), (k < 4) ? 1 : 0);
      check($sformatf("md.hilo%0d.B.bubble", k), int'(b_idex_bubble), (k < 4) ? 1 : 0);
      tick();
    end
    id_hilo_rd = 0; ex_md_start = 1;
    tick();
    ex_md_start = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("md.nohilo%0d.A.busy", k), int'(a_md_busy), (k < 4) ? 1 : 0);
      check($sformatf("md.nohilo%0d.A.bubble", k), int'(a_idex_bubble), 0);
      tick();
    end

    // Taken branch together with load hazard and mult/div issue.
    do_reset();
    ex_branch = 1; ex_zf = 1; ex_memrd = 1; ex_rt = 5'd5; id_rs = 5'd5; ex_md_start = 1;
    settle();
    check("br.A.clear1", int'(a_clear1), 1);
    check("br.A.bubble", int'(a_idex_bubble), 0);
    check("br.B.bubble", int'(b_idex_bubble), 0);
    tick();
    idle_inputs();
    settle();
    check("br.next.A.md_busy", int'(a_md_busy), 0);
    check("br.next.B.bubble", int'(b_idex_bubble), 0);
    check("br.A.flush_cnt", int'(a_flush_cnt), 1);
    check("br.A.stall_cnt", int'(a_stall_cnt), 0);
    tick();

    // Stall counter saturation, clear priority, and reset mid-LD_WAIT.
    do_reset();
    ex_memrd = 1; ex_rt = 5'd9; id_rs = 5'd9;
    for (int k = 0; k < 20; k++) step();
    settle();
    check("sat.B.stall_cnt", int'(b_stall_cnt), 15);
    check("sat.A.stall_cnt", int'(a_stall_cnt), 20);
    tick();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    settle();
    check("clr.B.stall_cnt", int'(b_stall_cnt), 0);
    check("clr.A.stall_cnt", int'(a_stall_cnt), 0);
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) step();
    ex_memrd = 1; ex_rt = 5'd9; id_rs = 5'd9;
    tick();
    idle_inputs();
    rst = 1;
    settle();
    check("rstwait.during.B.pc_wr", int'(b_pc_wr), 1);
    tick();
    rst = 0;
    settle();
    check("rstwait.B.pc_wr", int'(b_pc_wr), 1);
    check("rstwait.B.stall_cnt", int'(b_stall_cnt), 0);
    check("rstwait.B.flush_cnt", int'(b_flush_cnt), 0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      ex_branch   = ($urandom_range(0, 99) < 15);
      ex_zf       = $urandom_range(0, 1) == 1;
      ex_jump     = ($urandom_range(0, 99) < 5);
      ex_memrd    = ($urandom_range(0, 99) < 30);
      ex_md_start = ($urandom_range(0, 99) < 10);
      id_hilo_rd  = ($urandom_range(0, 99) < 30);
      id_md_op    = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 9) == 0) begin
        ex_rt = 5'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
      end else begin
        ex_rt = 5'($urandom_range(0, 3)); id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
